// File: rtl/nios2_onchip_mem_dp.sv
// nios2_onchip_mem_dp: two Avalon-MM style slaves (s1, s2) sharing one single-ported
// DEPTH x DATA_WIDTH array. One access per cycle; round-robin arbitration on conflict.
// Reads return READ_LATENCY (1 or 2) cycles after grant.
// Optional per-byte even parity storage and sticky error flag: define ONCHIP_MEM_PARITY_EN.
module nios2_onchip_mem_dp #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned DEPTH        = 9896,
  parameter int unsigned READ_LATENCY = 1,
  parameter string       INIT_FILE    = "onchip_mem.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest
`ifdef ONCHIP_MEM_PARITY_EN
  ,
  output logic                    parity_error
`endif
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  ptr_q;          // 0: s1 wins a conflict, 1: s2 wins
  logic                  req1_c;
  logic                  req2_c;
  logic                  run_c;
  logic                  gnt1_c;
  logic                  gnt2_c;
  logic [ADDR_WIDTH-1:0] acc_addr_c;
  logic [NUM_BYTES-1:0]  acc_be_c;
  logic [DATA_WIDTH-1:0] acc_wdata_c;
  logic                  acc_write_c;
  logic                  in_range_c;
  logic                  wr_c;
  logic                  rd_c;
  logic [DATA_WIDTH-1:0] rd_data_c;
  logic                  out_v_c;
  logic                  out_port_c;     // 0: s1, 1: s2
  logic [DATA_WIDTH-1:0] out_data_c;

  // Array preload is applied by the memory implementation flow from INIT_FILE.
  if (INIT_FILE == "") begin : g_no_init_file
  end

  // Request decode, round-robin grant and access mux
  always_comb begin
    req1_c      = s1_read | s1_write;
    req2_c      = s2_read | s2_write;
    run_c       = clken & ~reset;
    gnt1_c      = run_c & req1_c & (~req2_c | ~ptr_q);
    gnt2_c      = run_c & req2_c & (~req1_c | ptr_q);
    acc_addr_c  = s1_address;
    acc_be_c    = s1_byteenable;
    acc_wdata_c = s1_writedata;
    acc_write_c = s1_write;
    if (gnt2_c) begin
      acc_addr_c  = s2_address;
      acc_be_c    = s2_byteenable;
      acc_wdata_c = s2_writedata;
      acc_write_c = s2_write;
    end
    in_range_c = 32'(acc_addr_c) < DEPTH;
    wr_c       = (gnt1_c | gnt2_c) & acc_write_c;
    rd_c       = (gnt1_c | gnt2_c) & ~acc_write_c;
    rd_data_c  = in_range_c ? mem[acc_addr_c] : '0;
  end

  // A port waits when frozen/in reset, or when it requests and loses arbitration
  assign s1_waitrequest = ~run_c | (req1_c & ~gnt1_c);
  assign s2_waitrequest = ~run_c | (req2_c & ~gnt2_c);

  // Round-robin pointer hands priority to the loser of each contended grant
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else if (clken && req1_c && req2_c) begin
      ptr_q <= ~ptr_q;
    end
  end

  // Byte-lane write; out-of-range writes are dropped, contents survive reset
  always_ff @(posedge clk) begin
    if (wr_c && in_range_c) begin
      for (int b = 0; b < int'(NUM_BYTES); b++) begin
        if (acc_be_c[b]) begin
          mem[acc_addr_c][8*b +: 8] <= acc_wdata_c[8*b +: 8];
        end
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  st_v_q;
    logic                  st_port_q;
    logic [DATA_WIDTH-1:0] st_data_q;

    // Extra read stage between array and output registers
    always_ff @(posedge clk) begin
      if (reset) begin
        st_v_q    <= 1'b0;
        st_port_q <= 1'b0;
        st_data_q <= '0;
      end else if (clken) begin
        st_v_q    <= rd_c;
        st_port_q <= gnt2_c;
        st_data_q <= rd_data_c;
      end
    end

    assign out_v_c    = st_v_q;
    assign out_port_c = st_port_q;
    assign out_data_c = st_data_q;
  end else begin : g_lat1
    assign out_v_c    = rd_c;
    assign out_port_c = gnt2_c;
    assign out_data_c = rd_data_c;
  end

  // Output registers: readdata is zero whenever readdatavalid is low
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_readdatavalid <= 1'b0;
      s1_readdata      <= '0;
      s2_readdatavalid <= 1'b0;
      s2_readdata      <= '0;
    end else if (clken) begin
      s1_readdatavalid <= out_v_c & ~out_port_c;
      s1_readdata      <= (out_v_c && !out_port_c) ? out_data_c : '0;
      s2_readdatavalid <= out_v_c & out_port_c;
      s2_readdata      <= (out_v_c && out_port_c) ? out_data_c : '0;
    end
  end

`ifdef ONCHIP_MEM_PARITY_EN
  logic [NUM_BYTES-1:0] par_mem [DEPTH];
  logic                 par_err_c;

  function automatic logic [NUM_BYTES-1:0] byte_parity(input logic [DATA_WIDTH-1:0] d);
    logic [NUM_BYTES-1:0] p;
    for (int b = 0; b < int'(NUM_BYTES); b++) begin
      p[b] = ^d[8*b +: 8];
    end
    return p;
  endfunction

  // Parity bits follow the same byte-lane write as the data
  always_ff @(posedge clk) begin
    if (wr_c && in_range_c) begin
      for (int b = 0; b < int'(NUM_BYTES); b++) begin
        if (acc_be_c[b]) begin
          par_mem[acc_addr_c][b] <= ^acc_wdata_c[8*b +: 8];
        end
      end
    end
  end

  // Check stored parity against data on every in-range read
  always_comb begin
    par_err_c = rd_c & in_range_c & (byte_parity(mem[acc_addr_c]) != par_mem[acc_addr_c]);
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_error <= 1'b0;
    end else if (par_err_c) begin
      parity_error <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_nios2_onchip_mem_dp.sv
// Scoreboard bench for nios2_onchip_mem_dp (READ_LATENCY = 2, DEPTH = 9896).
module tb_nios2_onchip_mem_dp;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 14;
  localparam int          LAT = 2;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          clken;
  logic [AW-1:0] s1_address, s2_address;
  logic          s1_read, s1_write, s2_read, s2_write;
  logic [3:0]    s1_byteenable, s2_byteenable;
  logic [DW-1:0] s1_writedata, s2_writedata;
  logic [DW-1:0] s1_readdata, s2_readdata;
  logic          s1_readdatavalid, s2_readdatavalid;
  logic          s1_waitrequest, s2_waitrequest;
`ifdef ONCHIP_MEM_PARITY_EN
  logic          parity_error;
`endif

  exp_t exp1[$];
  exp_t exp2[$];
  exp_t e1, e2;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  nios2_onchip_mem_dp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(9896), .READ_LATENCY(LAT), .INIT_FILE("onchip_mem.hex")
  ) dut (
    .clk(clk), .reset(reset), .clken(clken),
    .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
    .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid), .s1_waitrequest(s1_waitrequest),
    .s2_address(s2_address), .s2_read(s2_read), .s2_write(s2_write),
    .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid), .s2_waitrequest(s2_waitrequest)
`ifdef ONCHIP_MEM_PARITY_EN
    , .parity_error(parity_error)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single uncontended access: expects immediate grant, queues read expectation
  task automatic access(input bit port, input bit wr, input logic [AW-1:0] addr,
                        input logic [3:0] be, input logic [DW-1:0] wdata,
                        input logic [DW-1:0] rexp, input bit push);
    exp_t e;
    if (!port) begin
      s1_address = addr; s1_write = wr; s1_read = !wr; s1_byteenable = be; s1_writedata = wdata;
    end else begin
      s2_address = addr; s2_write = wr; s2_read = !wr; s2_byteenable = be; s2_writedata = wdata;
    end
    #1;
    chk(port ? "s2 uncontended waitrequest" : "s1 uncontended waitrequest",
        port ? s2_waitrequest : s1_waitrequest, 0);
    if (!wr && push) begin
      e.data = rexp;
      e.cyc  = cyc + LAT;
      if (port) exp2.push_back(e); else exp1.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!port) begin s1_read = 0; s1_write = 0; end
    else       begin s2_read = 0; s2_write = 0; end
  endtask

  // Monitor: pop and compare on each readdatavalid; idle readdata must be zero
  always @(negedge clk) begin
    if (mon_en) begin
      if (s1_readdatavalid) begin
        if (exp1.size() == 0) chk("s1 unexpected readdatavalid", 1, 0);
        else begin
          e1 = exp1.pop_front();
          chk("s1 readdata", s1_readdata, e1.data);
          chk("s1 readdatavalid cycle", 64'(cyc), 64'(e1.cyc));
        end
      end else chk("s1 idle readdata", s1_readdata, 0);
      if (s2_readdatavalid) begin
        if (exp2.size() == 0) chk("s2 unexpected readdatavalid", 1, 0);
        else begin
          e2 = exp2.pop_front();
          chk("s2 readdata", s2_readdata, e2.data);
          chk("s2 readdatavalid cycle", 64'(cyc), 64'(e2.cyc));
        end
      end else chk("s2 idle readdata", s2_readdata, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    reset = 1; clken = 1;
    s1_address = '0; s1_read = 1; s1_write = 0; s1_byteenable = 4'hF; s1_writedata = '0;
    s2_address = '0; s2_read = 0; s2_write = 1; s2_byteenable = 4'hF; s2_writedata = '0;
    tick(); tick();
    chk("reset s1_waitrequest", s1_waitrequest, 1);
    chk("reset s2_waitrequest", s2_waitrequest, 1);
    chk("reset s1_readdatavalid", s1_readdatavalid, 0);
    chk("reset s2_readdatavalid", s2_readdatavalid, 0);
    chk("reset s1_readdata", s1_readdata, 0);
    chk("reset s2_readdata", s2_readdata, 0);
    s1_read = 0; s2_write = 0; reset = 0;
    mon_en = 1;
    tick();

    // Write then read on the other port, granted the very next cycle
    access(0, 1, 14'h10, 4'hF, 32'h12345678, 0, 0);
    access(1, 0, 14'h10, 4'hF, 0, 32'h12345678, 1);

    // Byte-enable merges
    access(0, 1, 14'h20, 4'hF, 32'hAABBCCDD, 0, 0);
    access(1, 1, 14'h20, 4'h1, 32'h00000011, 0, 0);
    access(0, 0, 14'h20, 4'hF, 0, 32'hAABBCC11, 1);
    access(0, 1, 14'h20, 4'h4, 32'h00EE0000, 0, 0);
    access(1, 0, 14'h20, 4'hF, 0, 32'hAAEECC11, 1);

    // Back-to-back uncontended reads on s1
    access(0, 0, 14'h10, 4'hF, 0, 32'h12345678, 1);
    access(0, 0, 14'h20, 4'hF, 0, 32'hAAEECC11, 1);
    access(0, 0, 14'h10, 4'hF, 0, 32'h12345678, 1);
    repeat (4) tick();

    // Contention right after reset: s1, s2, s1, s2
    reset = 1; tick(); reset = 0;
    s1_address = 14'h10; s2_address = 14'h20; s1_read = 1; s2_read = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("arb%0d s1_waitrequest", i), s1_waitrequest, (i % 2) == 1);
      chk($sformatf("arb%0d s2_waitrequest", i), s2_waitrequest, (i % 2) == 0);
      e.cyc = cyc + LAT;
      if (i % 2 == 0) begin e.data = 32'h12345678; exp1.push_back(e); end
      else            begin e.data = 32'hAAEECC11; exp2.push_back(e); end
      @(posedge clk); #1;
    end
    s1_read = 0; s2_read = 0;
    repeat (4) tick();

    // Address range boundary, no aliasing to address 0
    access(0, 1, 14'd0,    4'hF, 32'hCAFEF00D, 0, 0);
    access(0, 1, 14'd9895, 4'hF, 32'h5A5A5A5A, 0, 0);
    access(1, 1, 14'd9896, 4'hF, 32'hDEADBEEF, 0, 0);
    access(0, 0, 14'd9896, 4'hF, 0, 32'h0, 1);
    access(1, 0, 14'd0,    4'hF, 0, 32'hCAFEF00D, 1);
    access(0, 0, 14'd9895, 4'hF, 0, 32'h5A5A5A5A, 1);
    access(1, 0, 14'h3FFF, 4'hF, 0, 32'h0, 1);
    repeat (4) tick();

    // Reset one cycle after a read grant discards it; contents survive
    access(0, 0, 14'h10, 4'hF, 0, 0, 0);
    reset = 1; tick(); reset = 0;
    repeat (3) tick();
    access(0, 0, 14'h10, 4'hF, 0, 32'h12345678, 1);
    repeat (4) tick();

    // clken low for 3 cycles mid-read delays readdatavalid by 3
    s1_address = 14'h20; s1_read = 1;
    #1;
    chk("clken read s1_waitrequest", s1_waitrequest, 0);
    e.data = 32'hAAEECC11; e.cyc = cyc + LAT + 3; exp1.push_back(e);
    @(posedge clk); #1;
    s1_read = 0; clken = 0; s2_address = 14'h10; s2_read = 1;
    #1;
    chk("clken low s1_waitrequest", s1_waitrequest, 1);
    chk("clken low s2_waitrequest", s2_waitrequest, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    s2_read = 0; clken = 1;
    repeat (6) tick();

`ifdef ONCHIP_MEM_PARITY_EN
    chk("parity_error clean", parity_error, 0);
    access(0, 1, 14'h30, 4'hF, 32'h01020304, 0, 0);
    dut.par_mem[14'h30][0] = ~dut.par_mem[14'h30][0];
    access(0, 0, 14'h30, 4'hF, 0, 32'h01020304, 1);
    chk("parity_error set", parity_error, 1);
    repeat (4) tick();
    chk("parity_error sticky", parity_error, 1);
    reset = 1; tick(); reset = 0;
    chk("parity_error cleared", parity_error, 0);
`endif

    for (int i = 0; i < 40 && (exp1.size() != 0 || exp2.size() != 0); i++) tick();
    chk("s1 scoreboard drained", 64'(exp1.size()), 0);
    chk("s2 scoreboard drained", 64'(exp2.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nios2_onchip_mem_dp.md
NIOS2_ONCHIP_MEM_DP -- requirements
Module: nios2_onchip_mem_dp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 14, word-address width.
REQ-003 SHALL have parameter DEPTH, default 9896, number of words (DEPTH <= 2**ADDR_WIDTH).
REQ-004 SHALL have parameter READ_LATENCY, default 1, read latency in cycles (legal values 1 or 2).
REQ-005 SHALL have parameter INIT_FILE, default "onchip_mem.hex", memory initialisation file.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port clken, input, 1, global clock enable.
REQ-009 SHALL have, for each port sN (N = 1, 2): sN_address in ADDR_WIDTH; sN_read in 1; sN_write in 1; sN_byteenable in DATA_WIDTH/8; sN_writedata in DATA_WIDTH.
REQ-010 SHALL have, for each port sN: sN_readdata out DATA_WIDTH; sN_readdatavalid out 1; sN_waitrequest out 1.
REQ-011 SHALL have parity_error, output, 1, present only with ONCHIP_MEM_PARITY_EN.

Function
REQ-012 SHALL implement one shared DEPTH x DATA_WIDTH array serving one access per cycle, arbitrated between s1 and s2.
REQ-013 A port SHALL request when sN_read or sN_write is high; sN_write high wins over sN_read (treated as write, no readdatavalid).
REQ-014 With a single requester, it SHALL be granted the same cycle (sN_waitrequest low).
REQ-015 With two requesters, the port named by a round-robin pointer SHALL be granted; the other SHALL see waitrequest high and hold its request.
REQ-016 The pointer SHALL move to the losing port after every contended grant and stay unchanged otherwise.
REQ-017 A granted write SHALL update only lanes with byteenable high, effective at the next edge.
REQ-018 A granted read SHALL assert sN_readdatavalid for one cycle exactly READ_LATENCY cycles after grant, with sN_readdata valid in that cycle.
REQ-019 sN_readdata SHALL return 0 in cycles where sN_readdatavalid is low.
REQ-020 A read granted in the cycle after a write to the same address SHALL return the new data; a read granted in the write's own cycle is not possible (one access per cycle).
REQ-021 Address >= DEPTH: writes SHALL be dropped; reads SHALL complete normally with readdata 0.
REQ-022 clken low SHALL freeze the arbiter, read pipeline and array, and force both waitrequests high.
REQ-023 Back-to-back reads on one port SHALL sustain one per cycle when uncontended.

Reset
REQ-024 reset SHALL clear all readdatavalid, readdata and parity_error to 0 and the pointer to s1 by the next edge.
REQ-025 Reset SHALL discard in-flight reads (no readdatavalid after reset asserts) and SHALL NOT alter array contents.
REQ-026 During reset both waitrequests SHALL be high.

Configuration
REQ-027 With ONCHIP_MEM_PARITY_EN defined, an even parity bit per byte SHALL be stored on write and checked on read.
REQ-028 With ONCHIP_MEM_PARITY_EN, a mismatch SHALL set sticky parity_error, cleared only by reset; data is returned unmodified.
REQ-029 Without ONCHIP_MEM_PARITY_EN, no parity storage or port SHALL exist; behaviour is otherwise identical.

Verification
REQ-030 s1 write 0x12345678 @0x10 with byteenable 0xF, then s2 read @0x10 -> s2_readdatavalid after READ_LATENCY cycles, s2_readdata 0x12345678.
REQ-031 Write 0xAABBCCDD @0x20, then write 0x00000011 with byteenable 0x1 -> read returns 0xAABBCC11.
REQ-032 s1 and s2 both read every cycle for 4 cycles after reset -> grants alternate s1, s2, s1, s2; each waitrequest high exactly in cycles it loses.
REQ-033 Read @9896 with DEPTH=9896 -> readdatavalid with readdata 0; a prior write to 9896 does not alias to address 0.
REQ-034 Read issued, reset pulsed one cycle later with READ_LATENCY=2 -> no readdatavalid; a later read of prior data still returns it.
REQ-035 clken low 3 cycles mid-read -> readdatavalid delayed by 3 cycles; with ONCHIP_MEM_PARITY_EN, a forced parity flip on read sets parity_error until reset.
